fifo_drain_ctrl: RTL and testbench
==================================

# fifo_drain_ctrl

Read-side drain engine for the FIFO memory. It consumes the FIFO monitor's `empty_ind`, `threshold_ind` and `underflow_ind` flags and issues `trans_read` requests to the FIFO. Returned words go into a small output buffer and are presented downstream on a valid/ready stream with burst framing (`m_last`). It sits between the FIFO read port and the downstream consumer. It is the reader counterpart to the write-side pointer/status logic.

## Interface
- `OSTD_NUM`, 8: FIFO depth in words; power of two, ≥ 4.
- `DATA_WIDTH`, 32: FIFO word width.
- `BURST_LEN`, 2: words per threshold-triggered burst; must be ≤ `OSTD_NUM/4`.
- `TIMEOUT_CYC`, 16: idle cycles with data present (below threshold) before single-word draining starts; ≥ 2.
- `OBUF_DEPTH`, 4: output buffer entries; power of two, ≥ 3.

Ports:
- `clk_in`  in  1  clock; all logic on the rising edge.
- `areset_b`  in  1  asynchronous reset, active low.
- `empty_ind`  in  1  FIFO empty, from the monitor.
- `threshold_ind`  in  1  FIFO holds ≥ `BURST_LEN` words, from the monitor.
- `underflow_ind`  in  1  monitor underflow flag.
- `flush`  in  1  synchronous abort, one-cycle pulse.
- `trans_read`  out  1  FIFO read request, one word per asserted cycle.
- `fifo_rdata`  in  `DATA_WIDTH`  read data, valid the cycle after `trans_read`.
- `m_valid`  out  1  downstream word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  `DATA_WIDTH`  downstream word.
- `m_last`  out  1  final word of a burst or single transfer.
- `busy`  out  1  FSM not in IDLE, or words in flight, or buffer not empty.
- `err_underflow`  out  1  sticky; set when `underflow_ind` is sampled high. Cleared only by reset.

## Operation
- **Reset values:** `trans_read`, `m_valid`, `m_last`, `busy`, `err_underflow` are 0; `m_data` is 0; FSM is IDLE; all counters and the buffer are cleared.
- **FSM states:** IDLE, BURST, SINGLE, WAIT.
- **IDLE:**
  - If `threshold_ind` = 1 and credit is available → BURST, with `beat_cnt` = 0.
  - Else, while `empty_ind` = 0, `idle_cnt` increments. When `idle_cnt` = `TIMEOUT_CYC`-1 and credit is available → SINGLE.
  - `idle_cnt` clears whenever `empty_ind` = 1 or the FSM leaves IDLE.
- **BURST:**
  - Assert `trans_read` on every cycle with credit.
  - The tag for each read is last = (`beat_cnt` == `BURST_LEN`-1).
  - After issuing the last read → WAIT.
  - Stalls (no credit) pause issue; the burst is never aborted except by `flush`.
- **SINGLE:** issue exactly one read tagged last, then → WAIT.
- **WAIT:** hold until the in-flight count is 0, then → IDLE. This guarantees `empty_ind` reflects the updated read pointer before the next decision.
- **Credit:** `obuf_count` + `inflight` < `OBUF_DEPTH`. `inflight` is 0..1, set by `trans_read` and cleared when data returns. The credit check ensures no returned word is ever dropped.
- **Read-data capture:** the returning word and its last tag are written into the output buffer in the cycle after `trans_read`.
- **Downstream handshake:**
  - A word transfers when `m_valid` && `m_ready`.
  - `m_data` and `m_last` are stable while `m_valid` is high and `m_ready` is low.
  - `m_valid` never drops without a transfer, except on `flush`.
- **`trans_read` is never asserted while `empty_ind` = 1.**
- **`flush`:**
  - Next cycle: FSM → IDLE, `trans_read` = 0, buffer cleared, `m_valid` = 0, `beat_cnt` and `idle_cnt` are 0.
  - Any word returning in the cycle after `flush` is discarded.
  - `flush` has priority over every other event in the same cycle.
- **`underflow_ind`** only sets `err_underflow`; it has no other effect on operation.

## Timing
- `trans_read` asserted in cycle N → `fifo_rdata` is sampled at the end of N+1 → `m_valid` is high in N+2 if the buffer was empty (2-cycle latency).
- IDLE→BURST decision: `threshold_ind` sampled in cycle N → first `trans_read` in cycle N+1.
- With `m_ready` held at 1, a burst sustains one word per cycle.
- Timeout: `empty_ind` low continuously from cycle N (below threshold) → `trans_read` in cycle N+`TIMEOUT_CYC`.
- Simultaneous buffer write and read in the same cycle leaves `obuf_count` unchanged.
- Counters and pointers wrap modulo `OBUF_DEPTH`.

## Structure
- **Package `fifo_drain_pkg`:** the FSM enum `drain_state_e` (IDLE, BURST, SINGLE, WAIT) and the buffer entry struct `{data, last}`.
- **Sub-module `drain_obuf`:** synchronous `OBUF_DEPTH`-entry FIFO with `push`, `pop`, `clear`, `count`, `empty`. It drives `m_data`, `m_last` and `m_valid` from its head entry.
- **Top level:** FSM, `beat_cnt`, `idle_cnt`, in-flight tracking, credit logic, and the sticky error flag.

## Test plan
- **Reset mid-burst:** assert `areset_b` low during BURST → all outputs 0 immediately, asynchronously. After release the FSM is in IDLE.
- **Threshold burst:** `BURST_LEN`=2, `threshold_ind`=1, words 0xA1, 0xA2 in the FIFO, `m_ready`=1 → `trans_read` for 2 cycles; `m_data` is 0xA1 then 0xA2; `m_last`=1 only on 0xA2.
- **Backpressure:** `m_ready`=0 during a burst → at most `OBUF_DEPTH` words are accepted and `trans_read` stalls. After `m_ready`=1 all words arrive in order with no loss or duplicate.
- **Timeout single-word drain:** one word (0x55) present, `threshold_ind`=0 → `trans_read` exactly 16 cycles later; `m_data`=0x55 with `m_last`=1; FSM returns to IDLE and does not read again once `empty_ind`=1.
- **Flush:** `flush` pulse with a read in flight and 2 words buffered → next cycle `m_valid`=0; the in-flight word never appears downstream; `busy`=0 within 2 cycles.
- **Underflow flag:** pulse `underflow_ind` for 1 cycle → `err_underflow`=1 and stays 1 until reset. Across all scenarios, `trans_read` is never high while `empty_ind`=1.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types for the FIFO read-side drain engine.
package fifo_drain_pkg;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {IDLE, BURST, SINGLE, WAIT} drain_state_e;
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } obuf_entry_t;
endpackage

// File: rtl/drain_obuf.sv
// drain_obuf: small output FIFO whose head entry drives the downstream stream.
module drain_obuf
   import fifo_drain_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic              clk_in,
   input  logic              areset_b,
   input  logic              clear,
   input  logic              push,
   input  obuf_entry_t       wr_entry,
   input  logic              m_ready,
   output logic              m_valid,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic [CW-1:0]     count,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);
   obuf_entry_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          pop;
   assign empty   = count == '0;
   assign m_valid = !empty;
   assign pop     = m_valid && m_ready;
   assign m_data  = mem[rd_ptr].data;
   assign m_last  = m_valid && mem[rd_ptr].last;
   always_ff @(posedge clk_in or negedge areset_b)
      if (!areset_b) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) mem[wr_ptr] <= wr_entry;
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + CW'(push) - CW'(pop);
      end
endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: drains the FIFO in threshold bursts or timed-out single words
// and streams the returned words downstream with burst framing.
module fifo_drain_ctrl
   import fifo_drain_pkg::*;
#(
   parameter int OSTD_NUM    = 8,
   parameter int DATA_WIDTH  = DATA_W,
   parameter int BURST_LEN   = 2,
   parameter int TIMEOUT_CYC = 16,
   parameter int OBUF_DEPTH  = 4
) (
   input  logic                  clk_in,
   input  logic                  areset_b,
   input  logic                  empty_ind,
   input  logic                  threshold_ind,
   input  logic                  underflow_ind,
   input  logic                  flush,
   output logic                  trans_read,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  err_underflow
);
   // a burst longer than a quarter of the FIFO is clamped
   localparam int BL = (BURST_LEN > OSTD_NUM / 4) ? OSTD_NUM / 4 : BURST_LEN;
   localparam int BW = (BL > 1) ? $clog2(BL) : 1;
   localparam int IW = $clog2(TIMEOUT_CYC);
   localparam int CW = $clog2(OBUF_DEPTH) + 1;

   drain_state_e  state, state_nx;
   logic [BW-1:0] beat_cnt;
   logic [IW-1:0] idle_cnt;
   logic [CW-1:0] obuf_count;
   logic          inflight, tag_last, credit, beat_end, timeout, obuf_empty;
   obuf_entry_t   wr_entry;

   // a read may only issue if its returning word is guaranteed a buffer slot
   assign credit   = obuf_count + CW'(inflight) < CW'(OBUF_DEPTH);
   assign beat_end = beat_cnt == BW'(BL - 1);
   assign timeout  = idle_cnt == IW'(TIMEOUT_CYC - 1);
   assign busy     = state != IDLE || inflight || !obuf_empty;
   assign wr_entry = '{data: fifo_rdata, last: tag_last};

   always_comb begin
      state_nx   = flush ? IDLE : state;
      trans_read = 1'b0;
      if (!flush)
         case (state)
            IDLE:   state_nx = (threshold_ind && credit) ? BURST :
                               (!empty_ind && timeout && credit) ? SINGLE : IDLE;
            BURST: begin
               trans_read = credit && !empty_ind;
               state_nx   = (trans_read && beat_end) ? WAIT : BURST;
            end
            SINGLE: begin
               trans_read = credit && !empty_ind;
               state_nx   = trans_read ? WAIT : SINGLE;
            end
            WAIT:   state_nx = inflight ? WAIT : IDLE;
            default: state_nx = IDLE;
         endcase
   end

   always_ff @(posedge clk_in or negedge areset_b)
      if (!areset_b) begin
         state         <= IDLE;
         beat_cnt      <= '0;
         idle_cnt      <= '0;
         inflight      <= 1'b0;
         tag_last      <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         state         <= state_nx;
         inflight      <= trans_read;
         tag_last      <= state == SINGLE || beat_end;
         beat_cnt      <= (flush || state != BURST) ? '0 : trans_read ? beat_cnt + BW'(1) : beat_cnt;
         idle_cnt      <= (flush || state != IDLE || state_nx != IDLE || empty_ind) ? '0 :
                          timeout ? idle_cnt : idle_cnt + IW'(1);
         err_underflow <= err_underflow | underflow_ind;
      end

   drain_obuf #(.DEPTH(OBUF_DEPTH), .CW(CW)) u_obuf (
      .clk_in   (clk_in),
      .areset_b (areset_b),
      .clear    (flush),
      .push     (inflight),
      .wr_entry (wr_entry),
      .m_ready  (m_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_last   (m_last),
      .count    (obuf_count),
      .empty    (obuf_empty)
   );
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// tb_fifo_drain_ctrl: randomized scoreboard bench; a queue models the FIFO and
// expected framing is derived from how many words each scenario loads.
module tb_fifo_drain_ctrl;
   localparam int DW = 32, BL = 2, TO = 16, OD = 4;

   logic          clk = 1'b0, areset_b = 1'b0, flush = 1'b0, m_ready = 1'b0, underflow_ind = 1'b0;
   logic          empty_ind, threshold_ind, trans_read, m_valid, m_last, busy, err_underflow;
   logic [DW-1:0] fifo_rdata = '0, m_data;

   always #5 clk = ~clk;

   fifo_drain_ctrl #(.OSTD_NUM(8), .DATA_WIDTH(DW), .BURST_LEN(BL), .TIMEOUT_CYC(TO), .OBUF_DEPTH(OD)) dut (
      .clk_in        (clk),
      .areset_b      (areset_b),
      .empty_ind     (empty_ind),
      .threshold_ind (threshold_ind),
      .underflow_ind (underflow_ind),
      .flush         (flush),
      .trans_read    (trans_read),
      .fifo_rdata    (fifo_rdata),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_last        (m_last),
      .busy          (busy),
      .err_underflow (err_underflow)
   );

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // FIFO memory model: level is registered, read data returns the cycle after a read
   logic [DW-1:0] fq[$];
   logic [DW-1:0] pend[$];
   logic [DW-1:0] scn[$];
   int pend_seq = 0, pend_done = 0;
   int level = 0, cyc = 0, rd_total = 0, load_cyc = 0, first_rd_cyc = -1;
   assign empty_ind     = level == 0;
   assign threshold_ind = level >= BL;

   always @(posedge clk) begin
      if (trans_read && fq.size() > 0) begin
         fifo_rdata <= fq.pop_front();
         rd_total = rd_total + 1;
         if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (pend_seq != pend_done) begin
         foreach (pend[i]) fq.push_back(pend[i]);
         pend_done    = pend_seq;
         load_cyc     = cyc + 1;
         first_rd_cyc = -1;
      end
      level <= fq.size();
      cyc = cyc + 1;
   end

   // scoreboard
   logic [DW-1:0] exp_data[$];
   bit            exp_last[$];
   int exp_rd = 0, exp_skip = 0, xfers = 0;

   // remaining words drain as full bursts while enough are present, the rest one by one
   task automatic expect_from(input int start);
      int k    = scn.size() - start;
      int full = (k / BL) * BL;
      exp_skip = exp_data.size();
      for (int j = 0; j < k; j++) begin
         exp_data.push_back(scn[start + j]);
         exp_last.push_back(j < full ? (j % BL == BL - 1) : 1'b1);
      end
   endtask

   logic          pv = 1'b0, pr = 1'b0, pf = 1'b0, pl = 1'b0;
   logic [DW-1:0] pd = '0;
   always @(negedge clk) begin
      if (areset_b) begin
         if (exp_rd < exp_skip) exp_rd = exp_skip;
         if (level == 0) chk("read_while_empty", trans_read, 0);
         if (pv && !pr && !pf) begin
            chk("hold_valid", m_valid, 1);
            chk("hold_data", m_data, pd);
            chk("hold_last", m_last, pl);
         end
         if (m_valid && m_ready) begin
            chk("word_expected", exp_rd < int'(exp_data.size()), 1);
            if (exp_rd < int'(exp_data.size())) begin
               chk("m_data", m_data, exp_data[exp_rd]);
               chk("m_last", m_last, exp_last[exp_rd]);
            end
            exp_rd++;
            xfers++;
         end
      end
      pv = areset_b && m_valid;
      pr = m_ready;
      pf = flush;
      pd = m_data;
      pl = m_last;
   end

   int rdy_mode = 0;
   initial forever begin
      @(posedge clk);
      #1 m_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_scn(input int n);
      scn.delete();
      for (int i = 0; i < n; i++) scn.push_back($urandom);
   endtask

   task automatic load();
      pend = scn;
      pend_seq++;
      expect_from(0);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (n < 400 && !(level == 0 && !busy && exp_rd >= int'(exp_data.size()))) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_drained"}, n < 400, 1);
      repeat (3) tick();
   endtask

   initial begin
      int rd0, n, mx;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_trans_read", trans_read, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err_underflow, 0);
      tick();
      areset_b = 1'b1;
      repeat (2) tick();

      rdy_mode = 1;
      scn = '{32'hA1, 32'hA2};
      rd0 = rd_total;
      load();
      wait_drain("burst");
      chk("burst_first_read_delay", first_rd_cyc - load_cyc, 1);
      chk("burst_reads", rd_total - rd0, 2);

      scn = '{32'h55};
      rd0 = rd_total;
      load();
      wait_drain("timeout");
      chk("timeout_delay", first_rd_cyc - load_cyc, TO);
      repeat (30) tick();
      chk("timeout_reads", rd_total - rd0, 1);

      rdy_mode = 0;
      repeat (2) tick();
      rand_scn(7);
      rd0 = rd_total;
      load();
      mx = 0;
      repeat (40) begin
         @(negedge clk);
         if (rd_total - rd0 > mx) mx = rd_total - rd0;
      end
      chk("bp_reads_stalled", rd_total - rd0, OD);
      chk("bp_max_outstanding_ok", mx <= OD, 1);
      rdy_mode = 1;
      wait_drain("backpressure");
      chk("bp_reads", rd_total - rd0, 7);

      rdy_mode = 0;
      repeat (2) tick();
      rand_scn(6);
      rd0 = rd_total;
      load();
      n = 0;
      while (n < 100 && !(trans_read && rd_total - rd0 == 2)) begin
         @(negedge clk);
         n++;
      end
      chk("flush_setup", n < 100, 1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      expect_from(rd_total - rd0);
      @(negedge clk);
      chk("flush_m_valid", m_valid, 0);
      chk("flush_busy", busy, 0);
      rdy_mode = 2;
      wait_drain("flush");
      chk("flush_reads", rd_total - rd0, 6);

      for (int s = 0; s < 12; s++) begin
         rdy_mode = $urandom_range(1, 2);
         n = $urandom_range(1, 7);
         rand_scn(n);
         rd0 = rd_total;
         load();
         wait_drain("random");
         chk("random_reads", rd_total - rd0, n);
      end

      tick();
      underflow_ind = 1'b1;
      tick();
      underflow_ind = 1'b0;
      @(negedge clk);
      chk("underflow_set", err_underflow, 1);
      repeat (10) tick();
      chk("underflow_sticky", err_underflow, 1);

      rdy_mode = 1;
      rand_scn(6);
      rd0 = rd_total;
      load();
      n = 0;
      while (n < 100 && !trans_read) begin
         @(negedge clk);
         n++;
      end
      chk("reset_setup", n < 100, 1);
      #2 areset_b = 1'b0;
      #1;
      chk("areset_trans_read", trans_read, 0);
      chk("areset_m_valid", m_valid, 0);
      chk("areset_m_last", m_last, 0);
      chk("areset_m_data", m_data, 0);
      chk("areset_busy", busy, 0);
      chk("areset_err", err_underflow, 0);
      repeat (2) @(posedge clk);
      #1 areset_b = 1'b1;
      expect_from(rd_total - rd0);
      @(negedge clk);
      chk("post_reset_idle", busy, 0);
      wait_drain("after_reset");
      chk("after_reset_reads", rd_total - rd0, 6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation did not complete, time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
